// File: rtl/irq_pkg.sv
// Shared constants and vector helpers for the interrupt controller.
// Provides the register map, RST opcode base, spurious vectors and
// the channel-to-vector mapping used by irq_ctrl.
package irq_pkg;

  localparam int MAX_IRQ = 8;

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_INSERV  = 2'd2;
  localparam logic [1:0] ADDR_BASE    = 2'd3;

  localparam logic [7:0] RST_OPC         = 8'hC7;
  localparam logic [7:0] SPUR_VEC_RST    = 8'hFF;
  localparam logic [3:0] SPUR_VEC_IM2_LO = 4'hE;

  // RST mode: RST n opcode (C7 | ch<<3); IM2 mode: {base, ch, 0}.
  function automatic logic [7:0] chan_vec(input logic im2, input logic [3:0] base_hi,
                                          input logic [2:0] ch);
    return im2 ? {base_hi, ch, 1'b0} : (RST_OPC | {2'b00, ch, 3'b000});
  endfunction

  function automatic logic [7:0] spur_vec(input logic im2, input logic [3:0] base_hi);
    return im2 ? {base_hi, SPUR_VEC_IM2_LO} : SPUR_VEC_RST;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports: vec (request bits), valid (any bit set), idx (index of lowest set bit).
module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] vec,
  output logic         valid,
  output logic [2:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    // Walk downward so the lowest set index is the last assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Z80 interrupt controller with per-channel enable, edge/level mode,
// pending/in-service tracking with nested priority, EOI and RST/IM2 vectors.
// Ports: clk, reset (sync, active high), irq[N_IRQ], m1_n/iorq_n (ACK when
// both low), cs_n/wr_n/addr/data_in (register bus), data_out (read data or
// vector), int_n (registered, active-low request to the CPU).
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int         N_IRQ     = 8,
  parameter logic [7:0] EDGE_MASK = 8'h00,
  parameter int         VEC_MODE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             m1_n,
  input  logic             iorq_n,
  input  logic             cs_n,
  input  logic             wr_n,
  input  logic [1:0]       addr,
  input  logic [7:0]       data_in,
  output logic [7:0]       data_out,
  output logic             int_n
);

  localparam logic [7:0] CH_MASK = 8'((16'd1 << N_IRQ) - 16'd1);
  localparam logic [7:0] EDGE_CH = EDGE_MASK & CH_MASK;
  localparam logic       IM2     = (VEC_MODE != 0);

  logic [7:0] irq_ext, clr, req;
  logic [7:0] irq_q, irq_d, rise_q, rise_d, pend_q, pend_d;
  logic [7:0] enable_q, enable_d, inserv_q, inserv_d, ack_vec_q, ack_vec_d;
  logic [3:0] base_q, base_d;
  logic [2:0] ack_ch_q, ack_ch_d, top_req, top_is;
  logic       ack_valid_q, ack_valid_d, ack_q, ack_d, wr_q, wr_d, int_n_q, int_n_d;
  logic       ack, ack_first, wr_en, eoi, req_valid, is_valid, qual;

  irq_prio_enc #(.N(MAX_IRQ)) u_enc_req (.vec(req),      .valid(req_valid), .idx(top_req));
  irq_prio_enc #(.N(MAX_IRQ)) u_enc_is  (.vec(inserv_q), .valid(is_valid),  .idx(top_is));

  always_comb begin
    irq_ext             = '0;
    irq_ext[N_IRQ-1:0]  = irq;

    ack       = !m1_n && !iorq_n;
    ack_first = ack && !ack_q;
    wr_en     = !cs_n && !wr_n;
    // EOI only on the leading cycle of a write strobe.
    eoi       = wr_en && !wr_q && (addr == ADDR_INSERV);

    req  = pend_q & enable_q;
    qual = req_valid && (!is_valid || (top_req < top_is));

    irq_d  = irq_ext;
    rise_d = irq_ext & ~irq_q & EDGE_CH;

    clr = '0;
    if (wr_en && addr == ADDR_PENDING) clr = data_in;
    if (ack_first && ack_valid_q) clr[ack_ch_q] = 1'b1;
    // Set beats clear on edge channels; level channels simply follow irq.
    pend_d = (EDGE_CH & (rise_q | (pend_q & ~clr))) | (~EDGE_CH & irq_ext);

    inserv_d = inserv_q;
    if (eoi && is_valid) inserv_d[top_is] = 1'b0;
    if (ack_first && ack_valid_q) inserv_d[ack_ch_q] = 1'b1;

    enable_d = enable_q;
    if (wr_en && addr == ADDR_ENABLE) enable_d = data_in & CH_MASK;
    base_d = base_q;
    if (wr_en && addr == ADDR_BASE) base_d = data_in[7:4];

    // The vector and the channel that ACK will commit are captured together,
    // so the INSERV bit set always matches the vector the CPU received.
    ack_vec_d   = ack_vec_q;
    ack_ch_d    = ack_ch_q;
    ack_valid_d = ack_valid_q;
    if (!ack) begin
      ack_ch_d    = top_req;
      ack_valid_d = qual;
      ack_vec_d   = qual ? chan_vec(IM2, base_q, top_req) : spur_vec(IM2, base_q);
    end

    ack_d   = ack;
    wr_d    = wr_en;
    int_n_d = !qual;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q       <= '0;
      rise_q      <= '0;
      pend_q      <= '0;
      enable_q    <= '0;
      inserv_q    <= '0;
      base_q      <= '0;
      ack_vec_q   <= SPUR_VEC_RST;
      ack_ch_q    <= '0;
      ack_valid_q <= 1'b0;
      // Treat an ACK already in progress at reset release as stale.
      ack_q       <= 1'b1;
      wr_q        <= 1'b0;
      int_n_q     <= 1'b1;
    end else begin
      irq_q       <= irq_d;
      rise_q      <= rise_d;
      pend_q      <= pend_d;
      enable_q    <= enable_d;
      inserv_q    <= inserv_d;
      base_q      <= base_d;
      ack_vec_q   <= ack_vec_d;
      ack_ch_q    <= ack_ch_d;
      ack_valid_q <= ack_valid_d;
      ack_q       <= ack_d;
      wr_q        <= wr_d;
      int_n_q     <= int_n_d;
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (ack) begin
      data_out = ack_vec_q;
    end else if (!cs_n && wr_n) begin
      case (addr)
        ADDR_ENABLE:  data_out = enable_q;
        ADDR_PENDING: data_out = pend_q;
        ADDR_INSERV:  data_out = inserv_q;
        default:      data_out = {base_q, 4'h0};
      endcase
    end
  end

  assign int_n = int_n_q;

endmodule
